// File: rtl/video_pkg.sv
// Shared types, defaults and the test-pattern function used by the pattern
// master and by anything that needs to predict its output.
package video_pkg;

  localparam int H_PIXELS_DEF = 800;
  localparam int V_PIXELS_DEF = 480;

  typedef logic [31:0] pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } pm_state_t;

  function automatic pix_t pattern_pix(input logic [7:0] x, input logic [7:0] y);
    return {8'h00, x, y, x ^ y};
  endfunction

endpackage

// File: rtl/avm_pattern_master_if.sv
// Avalon-MM request/response bundle between the pattern master and its
// memory responder.
interface avm_pattern_master_if;

  logic [31:0] avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/pixel_scan.sv
// Raster scan counter: x fastest, then y, with a running byte address that
// steps by one word per advance and wraps to BASE_ADDR after the last pixel.
module pixel_scan #(
  parameter int          H_PIXELS  = 800,
  parameter int          V_PIXELS  = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          XW        = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
  parameter int          YW        = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [31:0]   o_addr,
  output logic          o_last
);

  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [31:0]   r_addr;
  logic          w_x_wrap;

  assign w_x_wrap = (r_x == X_LAST);
  assign o_last   = w_x_wrap && (r_y == Y_LAST);
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_addr   = r_addr;

  // Wrapping on the last pixel lets the read pass start from (0,0) with no extra cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= BASE_ADDR;
    end else if (i_clear || (i_advance && o_last)) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= BASE_ADDR;
    end else if (i_advance) begin
      r_addr <= r_addr + 32'd4;
      if (w_x_wrap) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/avm_pattern_master.sv
// Avalon-MM initiator that writes a deterministic RGB test frame and can
// read it back, counting mismatching words.
module avm_pattern_master
  import video_pkg::*;
#(
  parameter int          H_PIXELS  = H_PIXELS_DEF,
  parameter int          V_PIXELS  = V_PIXELS_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start,
  input  logic                 verify_en,
  avm_pattern_master_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          err_count,
  output logic [31:0]          first_err_addr
);

  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

  pm_state_t     r_state;
  pm_state_t     w_state_nxt;
  logic          r_verify;
  logic [15:0]   r_err_count;
  logic [31:0]   r_first_err_addr;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [31:0]   w_addr;
  logic          w_last;
  logic          w_req;
  logic          w_acc;
  logic          w_clear;
  logic          w_mismatch;
  pix_t          w_exp;

  pixel_scan #(
    .H_PIXELS  (H_PIXELS),
    .V_PIXELS  (V_PIXELS),
    .BASE_ADDR (BASE_ADDR),
    .XW        (XW),
    .YW        (YW)
  ) u_scan (
    .i_clk     (sys_clk),
    .i_rst     (sys_rst),
    .i_clear   (w_clear),
    .i_advance (w_acc),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  assign w_exp      = pattern_pix(8'(w_x), 8'(w_y));
  assign w_req      = (r_state == WRITE) || (r_state == READ);
  assign w_acc      = w_req && !avm.avm_waitrequest;
  assign w_clear    = (r_state == IDLE);
  assign w_mismatch = (r_state == READ) && w_acc && (avm.avm_readdata != w_exp);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Request outputs decode purely from registered state and scan counters, so they hold under stall.
  always_comb begin
    w_state_nxt        = r_state;
    avm.avm_write      = 1'b0;
    avm.avm_read       = 1'b0;
    avm.avm_address    = 32'h0;
    avm.avm_writedata  = 32'h0;
    avm.avm_byteenable = 4'h0;
    busy               = 1'b0;
    done               = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = WRITE;
      end
      WRITE: begin
        avm.avm_write      = 1'b1;
        avm.avm_address    = w_addr;
        avm.avm_writedata  = w_exp;
        avm.avm_byteenable = 4'hF;
        busy               = 1'b1;
        if (w_acc && w_last) w_state_nxt = r_verify ? READ : DONE;
      end
      READ: begin
        avm.avm_read       = 1'b1;
        avm.avm_address    = w_addr;
        avm.avm_byteenable = 4'hF;
        busy               = 1'b1;
        if (w_acc && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // err_count only grows within a run, so zero means no mismatch has been recorded yet.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_verify         <= 1'b0;
      r_err_count      <= 16'h0;
      r_first_err_addr <= 32'h0;
    end else if ((r_state == IDLE) && start) begin
      r_verify         <= verify_en;
      r_err_count      <= 16'h0;
      r_first_err_addr <= 32'h0;
    end else if (w_mismatch) begin
      if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      if (r_err_count == 16'h0)    r_first_err_addr <= w_addr;
    end
  end

  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_avm_pattern_master.sv
// Directed bench for avm_pattern_master: a 4x2 frame instance against a small
// memory model, plus a 350x200 instance for base address and saturation.
module tb_avm_pattern_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, verify_en = 1'b0;
  logic        start2 = 1'b0, verify2 = 1'b0;
  logic        busy, done, busy2, done2;
  logic [15:0] err_count, err_count2;
  logic [31:0] first_err_addr, first2;

  int checks = 0;
  int errors = 0;

  avm_pattern_master_if bus ();
  avm_pattern_master_if bus2 ();

  avm_pattern_master #(.H_PIXELS(4), .V_PIXELS(2), .BASE_ADDR(32'h0000_0000)) dut (
    .sys_clk(clk), .sys_rst(rst), .start(start), .verify_en(verify_en), .avm(bus.master),
    .busy(busy), .done(done), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  avm_pattern_master #(.H_PIXELS(350), .V_PIXELS(200), .BASE_ADDR(32'h0000_1000)) dut_sat (
    .sys_clk(clk), .sys_rst(rst), .start(start2), .verify_en(verify2), .avm(bus2.master),
    .busy(busy2), .done(done2), .err_count(err_count2), .first_err_addr(first2)
  );

  always #5 clk = ~clk;

  // Hand-computed {00, x, y, x^y} for the 4x2 frame in scan order.
  logic [31:0] exp_data [8] = '{32'h0000_0000, 32'h0001_0001, 32'h0002_0002, 32'h0003_0003,
                                32'h0000_0101, 32'h0001_0100, 32'h0002_0103, 32'h0003_0102};

  logic [31:0] mem [8];
  logic [31:0] wr_addr_log [16];
  logic [31:0] wr_data_log [16];
  int n_wr, n_rd, done_cyc, hold_viol, both_high, be_bad, busy_bad;
  bit done_seen, done_after, corrupt_en;

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
  endtask

  // Runs one frame on the small instance as the responder; records what happened.
  task automatic drive_frame(input bit v, input bit stall, input int restart_at, input int budget);
    int cyc;
    int stall_left;
    bit held;
    logic [65:0] h_req;
    n_wr = 0; n_rd = 0; done_cyc = 0; hold_viol = 0; both_high = 0;
    be_bad = 0; busy_bad = 0; done_seen = 0; done_after = 0;
    stall_left = 0; held = 0; h_req = '0;
    @(negedge clk);
    start = 1'b1; verify_en = v;
    @(negedge clk);
    cyc = 1;
    while (!done_seen && cyc <= budget) begin
      start     = (cyc == restart_at);
      verify_en = (cyc == restart_at);
      if (bus.avm_write && bus.avm_read) both_high++;
      if (done) begin
        done_seen = 1; done_cyc = cyc;
        if (busy) busy_bad++;
        bus.avm_waitrequest = 1'b0;
      end else begin
        if (!busy) busy_bad++;
        if (bus.avm_write || bus.avm_read) begin
          if (bus.avm_byteenable !== 4'hF) be_bad++;
          bus.avm_readdata = mem[bus.avm_address[4:2]] ^
            ((corrupt_en && (bus.avm_address == 32'h8 || bus.avm_address == 32'h18)) ? 32'h1 : 32'h0);
          if (held && ({bus.avm_address, bus.avm_writedata, bus.avm_write, bus.avm_read} !== h_req))
            hold_viol++;
          if (stall_left > 0) begin
            bus.avm_waitrequest = 1'b1;
            stall_left--;
          end else if (stall && !held && (((n_wr + n_rd) % 2) == 1)) begin
            held = 1;
            h_req = {bus.avm_address, bus.avm_writedata, bus.avm_write, bus.avm_read};
            bus.avm_waitrequest = 1'b1;
            stall_left = 2;
          end else begin
            bus.avm_waitrequest = 1'b0;
            held = 0;
            if (bus.avm_write) begin
              mem[bus.avm_address[4:2]] = bus.avm_writedata;
              if (n_wr < 16) begin
                wr_addr_log[n_wr] = bus.avm_address;
                wr_data_log[n_wr] = bus.avm_writedata;
              end
              n_wr++;
            end
            if (bus.avm_read) n_rd++;
          end
        end else begin
          bus.avm_waitrequest = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    done_after = done;
    start = 1'b0; verify_en = 1'b0;
    bus.avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.avm_byteenable} !== 70'h0) begin
      errors++; $display("FAIL reset_bus got=%h exp=0", {bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.avm_byteenable}); end
    checks++; if ({busy, done, err_count, first_err_addr} !== 50'h0) begin
      errors++; $display("FAIL reset_status got=%h exp=0", {busy, done, err_count, first_err_addr}); end
    checks++; if ({bus2.avm_address, bus2.avm_byteenable, busy2, done2} !== 38'h0) begin
      errors++; $display("FAIL reset_sat got=%h exp=0", {bus2.avm_address, bus2.avm_byteenable, busy2, done2}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_only();
    clear_mem();
    drive_frame(1'b0, 1'b0, 0, 100);
    checks++; if (!done_seen || done_cyc != 9) begin
      errors++; $display("FAIL wo_done_cycle got=%0d seen=%0d exp=9", done_cyc, done_seen); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL wo_done_width got=%b exp=0", done_after); end
    checks++; if (n_wr != 8 || n_rd != 0) begin errors++; $display("FAIL wo_count wr=%0d rd=%0d exp 8/0", n_wr, n_rd); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (wr_addr_log[i] !== 32'(4 * i) || wr_data_log[i] !== exp_data[i]) begin
        errors++; $display("FAIL wo_pix%0d got=%h/%h exp=%h/%h", i, wr_addr_log[i], wr_data_log[i], 4 * i, exp_data[i]); end
    end
    checks++; if (wr_data_log[5] !== 32'h0001_0100) begin errors++; $display("FAIL wo_x1y1 got=%h exp=00010100", wr_data_log[5]); end
    checks++; if (busy_bad != 0 || be_bad != 0 || both_high != 0) begin
      errors++; $display("FAIL wo_ctrl busy_bad=%0d be_bad=%0d both=%0d exp 0", busy_bad, be_bad, both_high); end
  endtask

  task automatic test_stall();
    clear_mem();
    drive_frame(1'b0, 1'b1, 0, 200);
    checks++; if (n_wr != 8) begin errors++; $display("FAIL st_count got=%0d exp=8", n_wr); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL st_hold got=%0d exp=0", hold_viol); end
    checks++; if (!done_seen || done_cyc != 21) begin errors++; $display("FAIL st_done_cycle got=%0d exp=21", done_cyc); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (wr_addr_log[i] !== 32'(4 * i) || wr_data_log[i] !== exp_data[i]) begin
        errors++; $display("FAIL st_pix%0d got=%h/%h exp=%h/%h", i, wr_addr_log[i], wr_data_log[i], 4 * i, exp_data[i]); end
    end
  endtask

  task automatic test_verify();
    clear_mem();
    drive_frame(1'b1, 1'b0, 0, 100);
    checks++; if (n_wr != 8 || n_rd != 8) begin errors++; $display("FAIL vf_count wr=%0d rd=%0d exp 8/8", n_wr, n_rd); end
    checks++; if (!done_seen || done_cyc != 17) begin errors++; $display("FAIL vf_done_cycle got=%0d exp=17", done_cyc); end
    checks++; if (err_count !== 16'h0 || first_err_addr !== 32'h0) begin
      errors++; $display("FAIL vf_status got=%h/%h exp=0/0", err_count, first_err_addr); end
    checks++; if (both_high != 0 || busy_bad != 0) begin errors++; $display("FAIL vf_ctrl both=%0d busy_bad=%0d exp 0", both_high, busy_bad); end
  endtask

  task automatic test_fault();
    clear_mem();
    corrupt_en = 1'b1;
    drive_frame(1'b1, 1'b0, 0, 100);
    corrupt_en = 1'b0;
    checks++; if (n_rd != 8) begin errors++; $display("FAIL ft_reads got=%0d exp=8", n_rd); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL ft_err_count got=%0d exp=2", err_count); end
    checks++; if (first_err_addr !== 32'h8) begin errors++; $display("FAIL ft_first_addr got=%h exp=8", first_err_addr); end
    repeat (3) @(negedge clk);
    checks++; if (err_count !== 16'd2 || first_err_addr !== 32'h8) begin
      errors++; $display("FAIL ft_hold got=%h/%h exp=2/8", err_count, first_err_addr); end
  endtask

  task automatic test_busy_restart();
    rst = 1'b1; #1;
    checks++; if (err_count !== 16'h0 || first_err_addr !== 32'h0) begin
      errors++; $display("FAIL br_rst_status got=%h/%h exp=0/0", err_count, first_err_addr); end
    @(negedge clk); rst = 1'b0;
    clear_mem();
    drive_frame(1'b0, 1'b0, 3, 100);
    checks++; if (n_wr != 8 || n_rd != 0 || done_cyc != 9) begin
      errors++; $display("FAIL br_restart wr=%0d rd=%0d done=%0d exp 8/0/9", n_wr, n_rd, done_cyc); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.avm_write !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL br_mid_write got=%b/%b exp=1/1", bus.avm_write, busy); end
    rst = 1'b1; #1;
    checks++; if ({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.avm_byteenable, busy, done} !== 72'h0) begin
      errors++; $display("FAIL br_mid_reset got=%h exp=0", {bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata, bus.avm_byteenable, busy, done}); end
    @(negedge clk); rst = 1'b0;
    clear_mem();
    drive_frame(1'b1, 1'b0, 0, 100);
    checks++; if (n_wr != 8 || n_rd != 8 || done_cyc != 17 || err_count !== 16'h0) begin
      errors++; $display("FAIL br_rerun wr=%0d rd=%0d done=%0d err=%0d exp 8/8/17/0", n_wr, n_rd, done_cyc, err_count); end
    checks++; if (wr_addr_log[0] !== 32'h0 || wr_data_log[7] !== 32'h0003_0102) begin
      errors++; $display("FAIL br_rerun_pix got=%h/%h exp=0/00030102", wr_addr_log[0], wr_data_log[7]); end
  endtask

  task automatic test_saturation();
    int cyc, nw, nr;
    bit seen;
    logic [31:0] a_first, a_last, d_last;
    logic w_first;
    nw = 0; nr = 0; seen = 0; a_last = '0; d_last = '0;
    bus2.avm_waitrequest = 1'b0;
    bus2.avm_readdata = 32'hFFFF_FFFF;
    @(negedge clk); start2 = 1'b1; verify2 = 1'b1;
    @(negedge clk); start2 = 1'b0; verify2 = 1'b0;
    cyc = 1;
    a_first = bus2.avm_address;
    w_first = bus2.avm_write;
    while (!seen && cyc <= 150000) begin
      if (done2) seen = 1;
      if (bus2.avm_write) begin nw++; a_last = bus2.avm_address; d_last = bus2.avm_writedata; end
      if (bus2.avm_read) nr++;
      if (!seen) begin @(negedge clk); cyc++; end
    end
    checks++; if (w_first !== 1'b1 || a_first !== 32'h0000_1000) begin
      errors++; $display("FAIL sat_first_write got=%b/%h exp=1/00001000", w_first, a_first); end
    checks++; if (!seen || cyc != 140001) begin errors++; $display("FAIL sat_done got=%0d seen=%0d exp=140001", cyc, seen); end
    checks++; if (nw != 70000 || nr != 70000) begin errors++; $display("FAIL sat_count wr=%0d rd=%0d exp 70000", nw, nr); end
    checks++; if (a_last !== 32'h0004_55BC || d_last !== 32'h005D_C79A) begin
      errors++; $display("FAIL sat_last_pix got=%h/%h exp=000455bc/005dc79a", a_last, d_last); end
    checks++; if (err_count2 !== 16'hFFFF) begin errors++; $display("FAIL sat_err_count got=%h exp=ffff", err_count2); end
    checks++; if (first2 !== 32'h0000_1000) begin errors++; $display("FAIL sat_first_addr got=%h exp=00001000", first2); end
  endtask

  initial begin
    bus.avm_waitrequest  = 1'b0;
    bus.avm_readdata     = 32'h0;
    bus2.avm_waitrequest = 1'b0;
    bus2.avm_readdata    = 32'h0;
    corrupt_en           = 1'b0;
    test_reset();
    test_write_only();
    test_stall();
    test_verify();
    test_fault();
    test_busy_restart();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avm_pattern_master.md
# avm_pattern_master

Avalon-MM initiator that writes a deterministic RGB test frame into the memory space behind an `avalon_if` responder. It can optionally read the frame back and count mismatches. It sits in `Top` on the `sys_clk` domain and exercises the framebuffer path end to end before the video controller consumes it. It holds every request stable under `waitrequest`.

## Interface
- `H_PIXELS`, default 800: pixels per line.
- `V_PIXELS`, default 480: lines per frame.
- `BASE_ADDR`, default 32'h0000_0000: byte address of pixel (0,0).
- `sys_clk` in 1: system clock, 100 MHz.
- `sys_rst` in 1: one clock; reset is asynchronous and active-high.
- `start` in 1: 1-cycle pulse; ignored unless idle.
- `verify_en` in 1: sampled with `start`; 1 adds a read-back pass.
- `avm_address` out 32: byte address, always a multiple of 4.
- `avm_write` out 1: write request.
- `avm_read` out 1: read request.
- `avm_writedata` out 32: pixel word.
- `avm_byteenable` out 4: 4'hF while a request is active, else 4'h0.
- `avm_readdata` in 32: valid when `avm_read && !avm_waitrequest`.
- `avm_waitrequest` in 1: responder stall.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: 1-cycle pulse at the end of an operation.
- `err_count` out 16: read-back mismatches; saturates at 16'hFFFF.
- `first_err_addr` out 32: address of the first mismatch; 0 if none.

## Operation
- **Pattern for pixel (x,y):**
  - Data = {8'h00, x[7:0], y[7:0], x[7:0]^y[7:0]}.
  - Address = BASE_ADDR + 4*(y*H_PIXELS + x).
  - Scan order is x fastest, then y.
- **FSM states:**
  - IDLE: on `start`, clear x, y, `err_count` and `first_err_addr`, latch `verify_en`, go to WRITE.
  - WRITE: assert `avm_write` with the current pixel.
  - READ: assert `avm_read` with the current pixel address.
  - DONE: 1 cycle, pulse `done`, return to IDLE.
- **Transaction acceptance:** a request is accepted on a cycle where it is asserted and `avm_waitrequest`=0. Only then do x and y advance.
- **Stability under stall:** address, data, byteenable and the request strobe do not change while `avm_waitrequest`=1.
- **Last pixel of WRITE accepted:**
  - With latched `verify_en`=1: reset x and y to 0, go to READ.
  - Otherwise: go to DONE.
- **Read-back check:** on each accepted read, compare `avm_readdata` against the expected pattern.
  - On mismatch, increment `err_count`, saturating.
  - On the first mismatch only, also load `first_err_addr`.
  - After the last read is accepted, go to DONE.
- **Address arithmetic:** a running 32-bit address adds 4 per accepted pixel; no multiplier. x and y are $clog2-sized counters that wrap at H_PIXELS-1 and V_PIXELS-1.
- **Exclusive requests:** `avm_read` and `avm_write` are never high together.
- **`start` while busy:** ignored. It does not restart or queue.
- **Reset mid-transaction:** immediately drops `avm_read`/`avm_write`, returns to IDLE and clears all outputs. The responder must tolerate the abandoned request.

## Timing
- **Reset values:** every output is 0. `avm_byteenable`=4'h0 and the FSM is in IDLE.
- **After `start`:** `start` sampled at cycle 0. WRITE is entered and `avm_write` is high from cycle 1.
- **Throughput:** with `waitrequest` permanently low, one pixel per cycle. A frame write takes H*V cycles after the first request.
- **Read latency:** fixed 0; data arrives in the same cycle the read is accepted. There is no pipelined read and no `readdatavalid`.
- **WRITE → READ:** consecutive cycles; the request strobe switches without an idle gap.
- **`done`:** high for exactly 1 cycle, in the cycle after the last accepted transaction. `busy` falls in the same cycle `done` rises.
- **Status outputs:** `err_count` and `first_err_addr` are registered. They are stable from `done` until the next accepted `start`.

## Structure
- **Package `video_pkg`:**
  - Constants H_PIXELS_DEF and V_PIXELS_DEF.
  - Typedef `pix_t` (32-bit pixel word).
  - Enum `pm_state_t` {IDLE, WRITE, READ, DONE}.
  - Function `pattern_pix(x, y)`, shared with the bench scoreboard.
- **Sub-module `pixel_scan`:** x/y/address counter with an `advance` input, a `last` flag and a `clear` input. It is instantiated once and reused by both passes.

## Test plan
- **Write-only pass:** H=4, V=2, waitrequest=0, start with verify_en=0.
  - Exactly 8 writes to 0x0,0x4,…,0x1C.
  - Data at 0x14 (x=1,y=1) = 32'h0001_0100.
  - `done` pulses 9 cycles after `start`.
- **Stall:** waitrequest high for 3 cycles on every second request.
  - Address and data are held constant across each stall.
  - The write count is still 8.
- **Verify pass:** verify_en=1 against a bench memory model.
  - 8 writes then 8 reads.
  - `err_count`=0 and `first_err_addr`=0 at `done`.
- **Fault injection:** the model corrupts the word at 0x8 and 0x18.
  - `err_count`=2 and `first_err_addr`=0x8.
- **Busy and restart:**
  - A second `start` mid-frame has no effect.
  - `sys_rst` during WRITE clears all outputs within the same cycle.
  - A subsequent `start` runs a full, correct frame.
- **Saturation:** BASE_ADDR=0x1000 with an always-wrong model and H*V=70000.
  - First write address is 0x1000.
  - `err_count` saturates at 16'hFFFF.
